mux_arb: RTL
============

# mux_arb

Parametrised N-channel, W-bit registered multiplexer with a valid/ready handshake on every channel and on the output. It selects one source per cycle, either by an explicit select index or by round-robin arbitration, and registers the chosen word. The output is provided as true and complement copies. It sits between several producer blocks and one shared consumer, and is the clocked, arbitrated generalisation of the team's combinational 8-to-1 selector.

## Interface
Parameters:
- N, 8, number of input channels (2..16)
- W, 1, data width per channel
- SW, $clog2(N), select/index width (derived, not overridden)

Ports:
- CLK  input  1  clock; all state changes on rising edge
- RST_L  input  1  asynchronous, active-low reset
- EN_L  input  1  active-low enable; high blocks new acceptance
- MODE  input  1  0 = fixed select via SEL, 1 = round-robin
- SEL  input  SW  channel index used when MODE=0
- D  input  N*W  channel data, channel i at D[i*W +: W]
- VALID  input  N  per-channel data valid
- LAST  input  N  per-channel end-of-packet marker (used only with MUXARB_LOCK_EN)
- ACK  output  N  one-hot accept strobe; channel i transfers when VALID[i] && ACK[i]
- Y  output  W  registered selected data
- Y_L  output  W  bitwise complement of Y
- VOUT  output  1  Y holds a valid word
- READY  input  1  downstream accepts Y when VOUT && READY
- CH  output  SW  index of the channel that supplied Y

## Operation
- Output register has two states: EMPTY (VOUT=0) and FULL (VOUT=1).
- Acceptance is possible in a cycle when EN_L=0 and (VOUT=0 or READY=1).
- MODE=0: the candidate is SEL. It is granted if VALID[SEL]=1. If SEL >= N, there is no grant.
- MODE=1: candidates are scanned in the order ptr, ptr+1, … N-1, 0, … ptr-1. The first channel with VALID set is granted.
- ACK[g]=1 combinationally for the granted channel g only when acceptance is possible. All other ACK bits are 0. ACK never depends on READY alone when VOUT=0.
- On acceptance:
  - Y <= D[g]
  - CH <= g
  - VOUT <= 1
  - in MODE=1 only, ptr <= (g+1) mod N. This wraps correctly for non-power-of-two N.
- On drain without refill (VOUT && READY, no acceptance):
  - VOUT <= 0
  - Y <= 0
  - CH unchanged
- Simultaneous drain and accept: the new word replaces the old one with no bubble, and VOUT stays 1.
- EN_L=1: ACK=0. A held word still drains normally, so Y falls to 0 once empty.
- Y_L = ~Y at all times, including during reset.
- ptr does not change in MODE=0. A MODE change takes effect in the same cycle.

## Timing
- Reset (RST_L low, asynchronous):
  - Y=0, Y_L=all ones, VOUT=0, CH=0, ptr=0, lock cleared
  - ACK=0 while RST_L is low
- Latency is 1 cycle from the ACK/VALID transfer edge to VOUT=1 with the data.
- Throughput is one word per cycle while READY=1.
- Reset asserted mid-transfer discards the held word. No ACK is issued in the reset cycle.
- First acceptance after reset release happens on the first rising edge with RST_L=1.

## Configuration
- MUXARB_LOCK_EN defined:
  - Packet lock applies in MODE=1.
  - Accepting a word from channel g with LAST[g]=0 sets lock on g. While locked, only g can be granted, even if other channels are valid.
  - Accepting from g with LAST[g]=1 clears the lock.
  - The lock is also cleared by reset or when MODE=0.
  - ptr advances only on the LAST transfer.
- MUXARB_LOCK_EN undefined: LAST is ignored, and every word arbitrates independently.

## Test plan
- Reset: hold RST_L=0 with VALID=all ones -> Y=0, Y_L=all ones, VOUT=0, ACK=0. First edge after release with MODE=1 grants channel 0.
- Fixed select, N=8, W=4, MODE=0, SEL=5, D[5]=4'hA, VALID=8'hFF, READY=1 -> ACK=8'h20, next cycle Y=4'hA, Y_L=4'h5, CH=5. SEL=7 with VALID[7]=0 -> ACK=0, VOUT=0.
- Round-robin with all VALID=1 and READY=1 for 10 cycles -> CH sequence 0,1,…,7,0,1. With N=5 the wrap is 4 -> 0.
- Backpressure: READY=0 with VOUT=1 -> ACK=0 and Y stable. Then READY=1 with VALID[2] set -> same-cycle drain and refill, VOUT stays 1.
- EN_L=1 while FULL and READY=1 -> VOUT falls to 0, Y=0, Y_L=all ones, ACK=0 throughout.
- With MUXARB_LOCK_EN, MODE=1: channel 1 sends 3 words with LAST=0,0,1 while channel 2 is valid -> CH=1,1,1, then 2. Without the macro -> CH alternates 1,2,1.

Source files
------------

// File: rtl/mux_arb_if.sv
// mux_arb_if: channel-side and consumer-side signals of the N-channel arbitrated mux.
// Latency/backpressure: carries no state; ACK/VOUT/READY form the valid-ready handshakes.
// Ports: EN_L, MODE, SEL, D, VALID, LAST, READY into the mux; ACK, Y, Y_L, VOUT, CH out of it.
interface mux_arb_if #(
   parameter int N = 8,
   parameter int W = 1
);
   localparam int SW = $clog2(N);

   logic          EN_L;
   logic          MODE;
   logic [SW-1:0] SEL;
   logic [N*W-1:0] D;
   logic [N-1:0]  VALID;
   logic [N-1:0]  LAST;
   logic [N-1:0]  ACK;
   logic [W-1:0]  Y;
   logic [W-1:0]  Y_L;
   logic          VOUT;
   logic          READY;
   logic [SW-1:0] CH;

   // slave: the mux itself
   modport slave (
      input  EN_L, MODE, SEL, D, VALID, LAST, READY,
      output ACK, Y, Y_L, VOUT, CH
   );

   // master: producers plus consumer driving the mux
   modport master (
      output EN_L, MODE, SEL, D, VALID, LAST, READY,
      input  ACK, Y, Y_L, VOUT, CH
   );
endinterface

// File: rtl/mux_arb.sv
// mux_arb: N-channel, W-bit registered mux, fixed-select (MODE=0) or round-robin (MODE=1).
// Latency: 1 cycle from ACK/VALID transfer to VOUT with data; one word per cycle at READY=1.
// Backpressure: accepts only when EN_L=0 and the output register is empty or draining.
// Ports: CLK, RST_L (async active-low) plain; everything else through mux_arb_if.slave.
// Option: define MUXARB_LOCK_EN to hold round-robin grant on one channel until its LAST word.
module mux_arb #(
   parameter int N = 8,
   parameter int W = 1
) (
   input  logic    CLK,
   input  logic    RST_L,
   mux_arb_if.slave bus
);
   localparam int SW = $clog2(N);

   logic [SW-1:0] ptr;
   logic [W-1:0]  y_q;
   logic [SW-1:0] ch_q;
   logic          vout_q;

`ifdef MUXARB_LOCK_EN
   logic          lock_vld;
   logic [SW-1:0] lock_ch;
`else
   logic          unused_last;
   assign unused_last = ^bus.LAST;
`endif

   logic          accept_ok;
   logic          rr_vld;
   logic [SW-1:0] rr_ch;
   logic          grant_vld;
   logic [SW-1:0] grant_ch;
   logic          accept;
   logic [W-1:0]  sel_dat;
   logic [N-1:0]  ack;
   logic [SW-1:0] ptr_nxt;

   always_comb begin
      // RST_L gating keeps ACK low for the whole reset interval
      accept_ok = RST_L && !bus.EN_L && (!vout_q || bus.READY);

      // Round-robin scan starting at ptr, wrapping modulo N
      rr_vld = 1'b0;
      rr_ch  = '0;
      for (int i = 0; i < N; i++) begin
         int idx;
         idx = int'(ptr) + i;
         if (idx >= N) idx = idx - N;
         if (!rr_vld && bus.VALID[SW'(idx)]) begin
            rr_vld = 1'b1;
            rr_ch  = SW'(idx);
         end
      end
`ifdef MUXARB_LOCK_EN
      // A packet in flight owns the output even if other channels are valid
      if (lock_vld) begin
         rr_vld = bus.VALID[lock_ch];
         rr_ch  = lock_ch;
      end
`endif

      grant_vld = 1'b0;
      grant_ch  = '0;
      if (!bus.MODE) begin
         if (int'(bus.SEL) < N && bus.VALID[bus.SEL]) begin
            grant_vld = 1'b1;
            grant_ch  = bus.SEL;
         end
      end else begin
         grant_vld = rr_vld;
         grant_ch  = rr_ch;
      end

      accept = grant_vld && accept_ok;

      ack = '0;
      if (accept) ack[grant_ch] = 1'b1;

      sel_dat = '0;
      for (int i = 0; i < N; i++) begin
         if (SW'(i) == grant_ch) sel_dat = bus.D[i*W +: W];
      end

      // explicit wrap so non-power-of-two N never indexes past N-1
      ptr_nxt = (grant_ch == SW'(N-1)) ? '0 : grant_ch + SW'(1);
   end

   always_ff @(posedge CLK or negedge RST_L) begin
      if (!RST_L) begin
         ptr      <= '0;
         y_q      <= '0;
         ch_q     <= '0;
         vout_q   <= 1'b0;
`ifdef MUXARB_LOCK_EN
         lock_vld <= 1'b0;
         lock_ch  <= '0;
`endif
      end else begin
         if (accept) begin
            // covers simultaneous drain+refill: VOUT simply stays high
            y_q    <= sel_dat;
            ch_q   <= grant_ch;
            vout_q <= 1'b1;
            if (bus.MODE) begin
`ifdef MUXARB_LOCK_EN
               if (bus.LAST[grant_ch]) begin
                  ptr      <= ptr_nxt;
                  lock_vld <= 1'b0;
               end else begin
                  lock_vld <= 1'b1;
                  lock_ch  <= grant_ch;
               end
`else
               ptr <= ptr_nxt;
`endif
            end
         end else if (vout_q && bus.READY) begin
            // drained with nothing to replace it; CH keeps the last source
            vout_q <= 1'b0;
            y_q    <= '0;
         end
`ifdef MUXARB_LOCK_EN
         if (!bus.MODE) lock_vld <= 1'b0;
`endif
      end
   end

   assign bus.ACK  = ack;
   assign bus.Y    = y_q;
   assign bus.Y_L  = ~y_q;
   assign bus.VOUT = vout_q;
   assign bus.CH   = ch_q;
endmodule
